pipo_rr_arbiter: RTL and testbench

Round-robin arbiter and write sequencer that shares one WIDTH-bit parallel-in/parallel-out register among NREQ requesters. Each cycle it picks at most one requester, drives the register's parallel data and load strobe, and holds the register contents. An optional per-requester lock lets one requester take a bounded burst of consecutive writes. It sits between the requesting datapath blocks and the shared PIPO storage, and it contains that storage.

---
 rtl/pipo_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_pipo_rr_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipo_rr_arbiter.sv
// Round-robin arbiter with bounded burst lock, feeding a shared WIDTH-bit PIPO register.
// Grant/strobe/data are registered one edge after sampling; the register loads on the next edge.
module pipo_rr_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4,
  localparam int PTR_W    = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*WIDTH-1:0] din,
  output logic [NREQ-1:0]       gnt,
  output logic                  load,
  output logic [WIDTH-1:0]      d_out,
  output logic [WIDTH-1:0]      q,
  output logic [PTR_W-1:0]      owner,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [PTR_W:0] NREQ_X = (PTR_W + 1)'(NREQ);

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              load_q, load_d;
  logic [WIDTH-1:0]  d_out_q, d_out_d;
  logic [PTR_W-1:0]  win_q, win_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  q_q;
  logic [PTR_W-1:0]  owner_q;

  logic              found;
  logic [PTR_W-1:0]  win;
  logic [PTR_W:0]    sum;

  // Rotating search: first requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr_q} + (PTR_W + 1)'(i);
      if (sum >= NREQ_X) sum = sum - NREQ_X;
      if (!found && req[sum[PTR_W-1:0]]) begin
        found = 1'b1;
        win   = sum[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    gnt_d   = '0;
    load_d  = 1'b0;
    d_out_d = d_out_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    cnt_d   = '0;
    state_d = IDLE;
    if (found) begin
      gnt_d[win] = 1'b1;
      load_d     = 1'b1;
      d_out_d    = din[int'(win)*WIDTH +: WIDTH];
      win_d      = win;
      // Keep the pointer parked on a locking winner until its burst budget runs out.
      if (lock[win] && (cnt_q < CNT_W'(MAX_BURST - 1))) begin
        ptr_d   = win;
        cnt_d   = cnt_q + 1'b1;
        state_d = LOCKED;
      end else begin
        ptr_d   = (win == PTR_W'(NREQ - 1)) ? '0 : win + 1'b1;
        state_d = GRANT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      load_q  <= 1'b0;
      d_out_q <= '0;
      win_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      load_q  <= load_d;
      d_out_q <= d_out_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      if (load_q) begin
        q_q     <= d_out_q;
        owner_q <= win_q;
      end
    end
  end

  assign gnt       = gnt_q;
  assign load      = load_q;
  assign d_out     = d_out_q;
  assign q         = q_q;
  assign owner     = owner_q;
  assign busy      = (state_q == LOCKED);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pipo_rr_arbiter.sv
// Directed vector table plus short hand-written sequences for pipo_rr_arbiter (NREQ=4, WIDTH=4, MAX_BURST=4).
module tb_pipo_rr_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 4;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   lock;
  logic [NREQ*W-1:0] din;
  logic [NREQ-1:0]   gnt;
  logic              load;
  logic [W-1:0]      d_out;
  logic [W-1:0]      q;
  logic [1:0]        owner;
  logic              busy;
  logic [1:0]        state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  pipo_rr_arbiter #(.NREQ(NREQ), .WIDTH(W), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .din(din),
    .gnt(gnt), .load(load), .d_out(d_out), .q(q), .owner(owner),
    .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   lock;
    logic [NREQ*W-1:0] din;
    logic [NREQ-1:0]   gnt;
    logic              load;
    logic [W-1:0]      dout;
    logic [W-1:0]      q;
    logic [1:0]        owner;
    logic              busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [3:0] rq, logic [3:0] lk, logic [15:0] d,
                              logic [3:0] g, logic ld, logic [3:0] dq, logic [3:0] qq,
                              logic [1:0] ow, logic b);
    vec_t v;
    v.rst = r; v.req = rq; v.lock = lk; v.din = d; v.gnt = g; v.load = ld;
    v.dout = dq; v.q = qq; v.owner = ow; v.busy = b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // driver: apply inputs at negedge, let one rising edge pass, sample at next negedge
  task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] lk, input logic [15:0] d);
    rst = r; req = rq; lock = lk; din = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    chk({tag, ".gnt"},   32'(gnt),   32'(v.gnt));
    chk({tag, ".load"},  32'(load),  32'(v.load));
    chk({tag, ".d_out"}, 32'(d_out), 32'(v.dout));
    chk({tag, ".q"},     32'(q),     32'(v.q));
    chk({tag, ".owner"}, 32'(owner), 32'(v.owner));
    chk({tag, ".busy"},  32'(busy),  32'(v.busy));
    chk({tag, ".onehot"}, 32'($onehot0(gnt)), 32'd1);
  endtask

  localparam logic [15:0] D4321 = 16'h4321;

  initial begin
    rst = 1'b1; req = '0; lock = '0; din = '0;

    // reset (requests during reset ignored) then idle
    vecs.push_back(mk(1, 4'b1111, 4'b0000, D4321, 4'b0000, 0, 4'h0, 4'h0, 2'd0, 0));
    vecs.push_back(mk(1, 4'b0000, 4'b0000, D4321, 4'b0000, 0, 4'h0, 4'h0, 2'd0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 4'b0000, 4'b0000, D4321, 4'b0000, 0, 4'h0, 4'h0, 2'd0, 0));
    // single write from requester 2, q lands one edge later and holds
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 16'h0A00, 4'b0100, 1, 4'hA, 4'h0, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 0, 4'hA, 4'hA, 2'd2, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 0, 4'hA, 4'hA, 2'd2, 0));
    // round-robin fairness from ptr=0
    vecs.push_back(mk(1, 4'b0000, 4'b0000, D4321, 4'b0000, 0, 4'h0, 4'h0, 2'd0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, D4321, 4'b0001, 1, 4'h1, 4'h0, 2'd0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, D4321, 4'b0010, 1, 4'h2, 4'h1, 2'd0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, D4321, 4'b0100, 1, 4'h3, 4'h2, 2'd1, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, D4321, 4'b1000, 1, 4'h4, 4'h3, 2'd2, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, D4321, 4'b0001, 1, 4'h1, 4'h4, 2'd3, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, D4321, 4'b0010, 1, 4'h2, 4'h1, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, D4321, 4'b0000, 0, 4'h2, 4'h2, 2'd1, 0));
    // burst cap: 4 grants to requester 0, then 1, then another 4 to 0
    vecs.push_back(mk(1, 4'b0000, 4'b0000, D4321, 4'b0000, 0, 4'h0, 4'h0, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0011, 4'b0001, D4321, 4'b0001, 1, 4'h1, 4'h0, 2'd0, 1));
    vecs.push_back(mk(0, 4'b0011, 4'b0001, D4321, 4'b0001, 1, 4'h1, 4'h1, 2'd0, 1));
    vecs.push_back(mk(0, 4'b0011, 4'b0001, D4321, 4'b0001, 1, 4'h1, 4'h1, 2'd0, 1));
    vecs.push_back(mk(0, 4'b0011, 4'b0001, D4321, 4'b0001, 1, 4'h1, 4'h1, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0011, 4'b0001, D4321, 4'b0010, 1, 4'h2, 4'h1, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0011, 4'b0001, D4321, 4'b0001, 1, 4'h1, 4'h2, 2'd1, 1));
    vecs.push_back(mk(0, 4'b0011, 4'b0001, D4321, 4'b0001, 1, 4'h1, 4'h1, 2'd0, 1));
    vecs.push_back(mk(0, 4'b0011, 4'b0001, D4321, 4'b0001, 1, 4'h1, 4'h1, 2'd0, 1));
    vecs.push_back(mk(0, 4'b0011, 4'b0001, D4321, 4'b0001, 1, 4'h1, 4'h1, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, D4321, 4'b0000, 0, 4'h1, 4'h1, 2'd0, 0));
    // lock dropped after the 2nd grant: one more grant to 0, then 1
    vecs.push_back(mk(1, 4'b0000, 4'b0000, D4321, 4'b0000, 0, 4'h0, 4'h0, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0011, 4'b0001, D4321, 4'b0001, 1, 4'h1, 4'h0, 2'd0, 1));
    vecs.push_back(mk(0, 4'b0011, 4'b0001, D4321, 4'b0001, 1, 4'h1, 4'h1, 2'd0, 1));
    vecs.push_back(mk(0, 4'b0011, 4'b0000, D4321, 4'b0001, 1, 4'h1, 4'h1, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0011, 4'b0000, D4321, 4'b0010, 1, 4'h2, 4'h1, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, D4321, 4'b0000, 0, 4'h2, 4'h2, 2'd1, 0));
    // reset mid-burst: burst aborts, next search starts at index 0
    vecs.push_back(mk(1, 4'b0000, 4'b0000, D4321, 4'b0000, 0, 4'h0, 4'h0, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0110, 4'b0010, D4321, 4'b0010, 1, 4'h2, 4'h0, 2'd0, 1));
    vecs.push_back(mk(0, 4'b0110, 4'b0010, D4321, 4'b0010, 1, 4'h2, 4'h2, 2'd1, 1));
    vecs.push_back(mk(1, 4'b0110, 4'b0010, D4321, 4'b0000, 0, 4'h0, 4'h0, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0110, 4'b0000, D4321, 4'b0010, 1, 4'h2, 4'h0, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0110, 4'b0000, D4321, 4'b0100, 1, 4'h3, 4'h2, 2'd1, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, D4321, 4'b0000, 0, 4'h3, 4'h3, 2'd2, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].lock, vecs[i].din);
      check_vec(i, vecs[i]);
    end

    // hand sequence: locking requester 3 with wrap to 0; bounded wait for its grant
    drive(1, 4'b0000, 4'b0000, D4321);
    begin
      int waited;
      logic seen;
      waited = 0;
      seen   = 1'b0;
      rst = 1'b0; req = 4'b1000; lock = 4'b1000; din = D4321;
      while (!seen && waited < 6) begin
        @(posedge clk);
        @(negedge clk);
        waited++;
        if (gnt[3]) seen = 1'b1;
      end
      chk("wait_gnt3", 32'(seen), 32'd1);
      chk("gnt3_latency", 32'(waited), 32'd1);
      chk("gnt3_busy", 32'(busy), 32'd1);
    end
    // requester 0 joins while 3 is locked: 3 keeps the grant until its cap (4), then 0
    exp_q.push_back(4'h4);
    exp_q.push_back(4'h4);
    exp_q.push_back(4'h4);
    exp_q.push_back(4'h4);
    begin
      logic [3:0] exp_g[4];
      exp_g[0] = 4'b1000; exp_g[1] = 4'b1000; exp_g[2] = 4'b1000; exp_g[3] = 4'b0001;
      for (int k = 0; k < 4; k++) begin
        logic [W-1:0] e;
        drive(0, 4'b1001, 4'b1000, D4321);
        chk($sformatf("wrap_gnt%0d", k), 32'(gnt), 32'(exp_g[k]));
        e = exp_q.pop_front();
        chk($sformatf("wrap_q%0d", k), 32'(q), 32'(e));
      end
    end
    drive(0, 4'b0000, 4'b0000, D4321);
    chk("wrap_final_q", 32'(q), 32'h1);
    chk("wrap_final_owner", 32'(owner), 32'd0);
    chk("wrap_final_load", 32'(load), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
